// File: rtl/pwm_hum_pkg.sv
// Shared types and constants for the humidity-driven PWM fan ramp.
// Band encoding, band thresholds and per-band duty percentages.
package pwm_hum_pkg;

    typedef enum logic [1:0] {
        BAND_DRY   = 2'd0,
        BAND_MID   = 2'd1,
        BAND_HUMID = 2'd2,
        BAND_WET   = 2'd3
    } band_e;

    localparam int THR_MID   = 20;
    localparam int THR_HUMID = 50;
    localparam int THR_WET   = 80;
    localparam int HUM_MAX   = 100;

    localparam int DUTY_PCT [4] = '{80, 50, 20, 0};

    function automatic band_e band_of(input int h);
        band_e b;
        b = BAND_WET;
        unique case (1'b1)
            (h < THR_MID):                     b = BAND_DRY;
            (h >= THR_MID && h < THR_HUMID):   b = BAND_MID;
            (h >= THR_HUMID && h < THR_WET):   b = BAND_HUMID;
            (h >= THR_WET):                    b = BAND_WET;
            default:                           b = BAND_WET;
        endcase
        return b;
    endfunction

    function automatic int lower_thr(input band_e b);
        int t;
        t = 0;
        unique case (b)
            BAND_DRY:   t = 0;
            BAND_MID:   t = THR_MID;
            BAND_HUMID: t = THR_HUMID;
            BAND_WET:   t = THR_WET;
            default:    t = 0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM period counter, registered compare output
// and terminal-count tick.
module pwm_gen #(
    parameter int CNT_W  = 10,
    parameter int PERIOD = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        cnt_d = (cnt_q == TERM) ? '0 : cnt_q + ONE;
        pwm_d = en_i && (cnt_q < duty_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/pwm_hum_ramp.sv
// Humidity band FSM with downward hysteresis, driving a slew-limited
// PWM duty that only changes at period boundaries.
module pwm_hum_ramp
    import pwm_hum_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int PERIOD    = 999,
    parameter int RAMP_STEP = 8,
    parameter int HYST      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hum_valid,
    input  logic [6:0]       humidity,
    output logic             pwm,
    output logic [CNT_W-1:0] duty_cur,
    output logic [1:0]       band,
    output logic             period_tick,
    output logic             hum_err
);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

    function automatic logic [CNT_W-1:0] tgt_of(input band_e b);
        return CNT_W'((PERIOD * DUTY_PCT[int'(b)]) / 100);
    endfunction

    band_e            band_q, band_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] tgt;
    band_e            raw_b, hyst_b;
    int               hum;
    logic             tick;

    pwm_gen #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .duty_i (duty_q),
        .pwm_o  (pwm),
        .tick_o (tick)
    );

    always_comb begin
        band_d = band_q;
        err_d  = err_q;
        duty_d = duty_q;
        hum    = int'(humidity);
        raw_b  = band_of(hum);
        hyst_b = band_of(hum + HYST);
        if (hum_valid) begin
            if (hum > HUM_MAX) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
                if (raw_b > band_q) begin
                    band_d = raw_b;
                end else if (raw_b < band_q &&
                             hum + HYST < lower_thr(band_q)) begin
                    band_d = hyst_b;
                end
            end
        end
        // ramp sees the pre-edge band; a same-edge strobe waits a period
        tgt = en ? tgt_of(band_q) : '0;
        if (tick) begin
            if (tgt > duty_q) begin
                duty_d = (tgt - duty_q > STEP) ? duty_q + STEP : tgt;
            end else if (tgt < duty_q) begin
                duty_d = (duty_q - tgt > STEP) ? duty_q - STEP : tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            band_q <= BAND_WET;
            err_q  <= 1'b0;
            duty_q <= '0;
        end else begin
            band_q <= band_d;
            err_q  <= err_d;
            duty_q <= duty_d;
        end
    end

    assign duty_cur    = duty_q;
    assign band        = band_q;
    assign period_tick = tick;
    assign hum_err     = err_q;

endmodule

// File: doc/pwm_hum_ramp.md
PWM_HUM_RAMP -- requirements
Module: pwm_hum_ramp

Interface
REQ-001 Parameter CNT_W, default 10: PWM counter and duty width in bits.
REQ-002 Parameter PERIOD, default 999: terminal count, so one PWM period is PERIOD+1 clk cycles; PERIOD SHALL fit in CNT_W bits.
REQ-003 Parameter RAMP_STEP, default 8: maximum duty change per PWM period, in counts.
REQ-004 Parameter HYST, default 2: humidity hysteresis in percent for downward band moves.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  drive enable; low forces motor off.
REQ-008 hum_valid  input  1  one-cycle strobe qualifying humidity.
REQ-009 humidity  input  7  humidity sample, 0..100 percent, binary.
REQ-010 pwm  output  1  registered PWM drive.
REQ-011 duty_cur  output  CNT_W  duty currently applied, in counts.
REQ-012 band  output  2  current humidity band: 0 DRY, 1 MID, 2 HUMID, 3 WET.
REQ-013 period_tick  output  1  one-cycle pulse in the clk cycle where counter == PERIOD.
REQ-014 hum_err  output  1  last humidity sample was out of range.

Function
REQ-015 Counter SHALL count 0..PERIOD, then wrap to 0, and SHALL run continuously regardless of en.
REQ-016 pwm SHALL be registered as (en && counter < duty_cur), giving 1-cycle latency from counter to pin; duty_cur == 0 gives constant 0.
REQ-017 Raw band: humidity <20 -> DRY; 20..49 -> MID; 50..79 -> HUMID; >=80 -> WET.
REQ-018 Band target duty: DRY = PERIOD*80/100; MID = PERIOD*50/100; HUMID = PERIOD*20/100; WET = 0. All use integer truncation, giving 799/499/199/0 at defaults.
REQ-019 On hum_valid with humidity <= 100: hum_err SHALL clear.
REQ-020 Upward move (band update on that edge): if raw band > band, band SHALL become raw band; multi-band jumps are allowed.
REQ-021 Downward move (band update on that edge): if raw band < band, band SHALL move only when humidity + HYST < lower threshold of the current band (20/50/80), and SHALL then take the raw band of humidity + HYST.
REQ-022 If neither REQ-020 nor REQ-021 applies, band SHALL be held.
REQ-023 On hum_valid with humidity > 100: hum_err SHALL set and band SHALL be held.
REQ-024 Effective target SHALL be 0 when en == 0; otherwise it SHALL be the target duty of the registered band.
REQ-025 duty_cur SHALL change only on the edge where period_tick is high, moving toward the effective target by min(RAMP_STEP, |target - duty_cur|), so no PWM period is truncated or glitched.
REQ-026 Simultaneous hum_valid and period_tick: the ramp SHALL use the band value before that edge; the new band takes effect at the next period boundary.
REQ-027 en falling SHALL force pwm to 0 on the next clk edge, with duty_cur ramping down. en rising SHALL resume the ramp from the current duty_cur, not from 0.

Reset
REQ-028 On rst low, immediately and asynchronously: counter = 0, pwm = 0, duty_cur = 0, band = WET, period_tick = 0, hum_err = 0.
REQ-029 Reset mid-period or mid-ramp SHALL discard all progress; after release the counter restarts at 0 and the ramp starts from 0.

Structure
REQ-030 Shared package pwm_hum_pkg SHALL hold the band encoding typedef, threshold constants 20/50/80, and the duty-percent table 80/50/20/0.
REQ-031 Counter, compare and period_tick SHALL live in sub-module pwm_gen, parametrised by CNT_W and PERIOD. Band FSM, hysteresis and ramp SHALL stay in pwm_hum_ramp.

Verification
REQ-032 Reset release, no hum_valid -> band = 3, duty_cur = 0, pwm stays 0 for 5000 cycles; period_tick every 1000 cycles.
REQ-033 en = 1, humidity = 10 strobed -> band = 0; duty_cur rises by 8 per period to 799 after 100 periods (last step 7), then stays at 799 with pwm high 799 of every 1000 cycles.
REQ-034 Hysteresis from band 2: humidity 49 -> band stays 2; humidity 47 -> band 1; humidity 80 -> band 3 on the strobe edge.
REQ-035 humidity = 101 strobed -> hum_err = 1, band unchanged; next strobe of 30 -> hum_err = 0.
REQ-036 Ramp at duty 400, deassert en mid-period -> pwm = 0 on the next edge; duty_cur falls by 8 per period; re-assert en at duty 200 -> duty_cur climbs from 200.
REQ-037 Assert rst mid-ramp at counter = 537 -> all outputs return to reset values immediately; after release the counter restarts at 0.
